// File: rtl/cmd_proc_if.sv
// Command/response link between the UART wrapper and the command sequencer.
// The wrapper (master) presents an assembled 16-bit command and receives
// the consume pulse plus a one-byte acknowledge to transmit.
interface cmd_proc_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (output cmd, cmd_rdy, input clr_cmd_rdy, send_resp, resp);
  modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, send_resp, resp);
endinterface

// File: rtl/cmd_proc.sv
// Command sequencer: executes calibrate / move / move+fanfare commands,
// drives heading and ramped forward-speed targets to the motion controller,
// counts center-line crossings and acknowledges each completed command.
module cmd_proc #(
  parameter logic [9:0]  FRWRD_INC = 10'h020,
  parameter logic [9:0]  MAX_SPD   = 10'h300,
  parameter logic [11:0] ALIGN_TOL = 12'h030
) (
  input  logic        clk,
  input  logic        rst_n,
  cmd_proc_if.slave   cmd_bus,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cal_done,
  input  logic        cntrIR,
  output logic        strt_cal,
  output logic        moving,
  output logic [11:0] dsrd_hdng,
  output logic [9:0]  frwrd,
  output logic        fanfare
);

  typedef enum logic [2:0] {IDLE, CAL, HDNG, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [9:0] FRWRD_DEC = {FRWRD_INC[8:0], 1'b0};

  state_t      state, state_nxt;
  logic [11:0] dsrd_nxt;
  logic [9:0]  frwrd_nxt;
  logic        fan_q, fan_nxt;     // latched opcode bit 0: move ends with fanfare
  logic [4:0]  tgt_q, tgt_nxt;     // line crossings to travel (2 per square)
  logic [4:0]  cnt_q, cnt_nxt;     // line crossings seen so far
  logic        cntr_ff;
  logic        clr_c, resp_c;

  // heading error with 12-bit wrap; magnitude compared unsigned so the
  // -2048 corner (magnitude 0x800) is never treated as aligned
  logic [11:0] err, err_abs;
  logic        aligned;
  assign err     = heading - dsrd_hdng;
  assign err_abs = err[11] ? (~err + 12'd1) : err;
  assign aligned = (err_abs < ALIGN_TOL);

  // saturating speed step up, floored step down
  logic [10:0] frwrd_sum;
  logic [9:0]  frwrd_up, frwrd_dn;
  assign frwrd_sum = {1'b0, frwrd} + {1'b0, FRWRD_INC};
  assign frwrd_up  = (frwrd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : frwrd_sum[9:0];
  assign frwrd_dn  = (frwrd < FRWRD_DEC) ? 10'h000 : (frwrd - FRWRD_DEC);

  logic       ir_rise;
  logic [4:0] cnt_inc;
  assign ir_rise = cntrIR & ~cntr_ff;
  assign cnt_inc = cnt_q + 5'd1;

  assign moving              = (state == HDNG) || (state == RAMP_UP) || (state == RAMP_DOWN);
  assign cmd_bus.clr_cmd_rdy = clr_c;
  assign cmd_bus.send_resp   = resp_c;
  assign cmd_bus.resp        = 8'hA5;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dsrd_hdng <= 12'h000;
      frwrd     <= 10'h000;
      fan_q     <= 1'b0;
      tgt_q     <= 5'd0;
      cnt_q     <= 5'd0;
      cntr_ff   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dsrd_hdng <= dsrd_nxt;
      frwrd     <= frwrd_nxt;
      fan_q     <= fan_nxt;
      tgt_q     <= tgt_nxt;
      cnt_q     <= cnt_nxt;
      cntr_ff   <= cntrIR;
    end
  end

  // next-state, datapath updates and Mealy strobes
  always_comb begin
    state_nxt = state;
    dsrd_nxt  = dsrd_hdng;
    frwrd_nxt = frwrd;
    fan_nxt   = fan_q;
    tgt_nxt   = tgt_q;
    cnt_nxt   = cnt_q;
    clr_c     = 1'b0;
    resp_c    = 1'b0;
    strt_cal  = 1'b0;
    fanfare   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_bus.cmd_rdy) begin
          clr_c = 1'b1;
          case (cmd_bus.cmd[15:12])
            4'h0: begin
              strt_cal  = 1'b1;
              state_nxt = CAL;
            end
            4'h2, 4'h3: begin
              dsrd_nxt  = (cmd_bus.cmd[11:4] == 8'h00) ? 12'h000 : {cmd_bus.cmd[11:4], 4'hF};
              fan_nxt   = cmd_bus.cmd[12];
              tgt_nxt   = {cmd_bus.cmd[3:0], 1'b0};
              cnt_nxt   = 5'd0;
              frwrd_nxt = 10'h000;
              state_nxt = HDNG;
            end
            default: ;  // unknown opcode: consumed silently
          endcase
        end
      end
      CAL: begin
        if (cal_done) begin
          resp_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      HDNG: begin
        if (heading_rdy && aligned)
          state_nxt = (tgt_q == 5'd0) ? RAMP_DOWN : RAMP_UP;
      end
      RAMP_UP: begin
        if (heading_rdy)
          frwrd_nxt = frwrd_up;
        if (ir_rise) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == tgt_q)
            state_nxt = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (frwrd == 10'h000) begin
          resp_c    = 1'b1;
          fanfare   = fan_q;
          state_nxt = IDLE;
        end else if (heading_rdy) begin
          frwrd_nxt = frwrd_dn;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: calibrate, moves with ramp/saturation/wrap,
// misalignment, zero-square and unknown opcodes, reset mid-move.
module tb_cmd_proc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] heading = 12'h000;
  logic        heading_rdy = 1'b0;
  logic        cal_done = 1'b0;
  logic        cntrIR = 1'b0;
  logic        strt_cal, moving, fanfare;
  logic [11:0] dsrd_hdng;
  logic [9:0]  frwrd;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int fan_cnt = 0;
  int r0, f0;

  cmd_proc_if u_if ();

  cmd_proc u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_bus     (u_if),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .cal_done    (cal_done),
    .cntrIR      (cntrIR),
    .strt_cal    (strt_cal),
    .moving      (moving),
    .dsrd_hdng   (dsrd_hdng),
    .frwrd       (frwrd),
    .fanfare     (fanfare)
  );

  always #5 clk = ~clk;

  // count acknowledge and fanfare pulses as the DUT registers them
  always @(posedge clk) begin
    if (u_if.send_resp) resp_cnt <= resp_cnt + 1;
    if (fanfare)        fan_cnt  <= fan_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic hrdy();
    heading_rdy = 1'b1;
    @(negedge clk);
    heading_rdy = 1'b0;
    #1;
  endtask

  task automatic edge_ir();
    cntrIR = 1'b1;
    @(negedge clk);
    cntrIR = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] c, input string tag);
    u_if.cmd     = c;
    u_if.cmd_rdy = 1'b1;
    #1;
    chk({tag, "_clr"}, u_if.clr_cmd_rdy, 1);
    @(negedge clk);
    u_if.cmd_rdy = 1'b0;
    #1;
  endtask

  initial begin
    u_if.cmd     = 16'h0000;
    u_if.cmd_rdy = 1'b0;
    #3 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_clr",   u_if.clr_cmd_rdy, 0);
    chk("rst_cal",   strt_cal, 0);
    chk("rst_mov",   moving, 0);
    chk("rst_hdng",  dsrd_hdng, 12'h000);
    chk("rst_frwrd", frwrd, 10'h000);
    chk("rst_sresp", u_if.send_resp, 0);
    chk("rst_resp",  u_if.resp, 8'hA5);
    chk("rst_fan",   fanfare, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // calibrate
    r0 = resp_cnt;
    u_if.cmd = 16'h0000; u_if.cmd_rdy = 1'b1; #1;
    chk("cal_clr",  u_if.clr_cmd_rdy, 1);
    chk("cal_strt", strt_cal, 1);
    @(negedge clk); u_if.cmd_rdy = 1'b0; #1;
    chk("cal_strt_off", strt_cal, 0);
    chk("cal_mov",      moving, 0);
    cyc(49);
    chk("cal_wait", u_if.send_resp, 0);
    cal_done = 1'b1; #1;
    chk("cal_sresp", u_if.send_resp, 1);
    chk("cal_resp",  u_if.resp, 8'hA5);
    @(negedge clk); cal_done = 1'b0; #1;
    chk("cal_sresp_off", u_if.send_resp, 0);
    chk("cal_cnt", resp_cnt - r0, 1);

    // move 1 square, heading 0
    r0 = resp_cnt; f0 = fan_cnt;
    heading = 12'h000;
    issue(16'h2001, "mv1");
    chk("mv1_mov",  moving, 1);
    chk("mv1_hdng", dsrd_hdng, 12'h000);
    hrdy(); chk("mv1_f0", frwrd, 10'h000);
    hrdy(); chk("mv1_f1", frwrd, 10'h020);
    hrdy(); chk("mv1_f2", frwrd, 10'h040);
    hrdy(); chk("mv1_f3", frwrd, 10'h060);
    edge_ir();
    edge_ir();
    chk("mv1_hold", frwrd, 10'h060);
    hrdy(); chk("mv1_d1", frwrd, 10'h020);
    hrdy(); chk("mv1_d2", frwrd, 10'h000);
    chk("mv1_sresp", u_if.send_resp, 1);
    chk("mv1_fan",   fanfare, 0);
    cyc(1);
    chk("mv1_mov_off", moving, 0);
    chk("mv1_rcnt", resp_cnt - r0, 1);
    chk("mv1_fcnt", fan_cnt - f0, 0);

    // wrap + saturation + fanfare
    r0 = resp_cnt; f0 = fan_cnt;
    heading = 12'h800;
    issue(16'h37F2, "wr");
    chk("wr_hdng", dsrd_hdng, 12'h7FF);
    hrdy();
    repeat (30) hrdy();
    chk("wr_sat", frwrd, 10'h300);
    repeat (4) edge_ir();
    repeat (11) hrdy();
    chk("wr_d11", frwrd, 10'h040);
    hrdy();
    chk("wr_d12",   frwrd, 10'h000);
    chk("wr_sresp", u_if.send_resp, 1);
    chk("wr_fan",   fanfare, 1);
    cyc(1);
    chk("wr_mov_off", moving, 0);
    chk("wr_rcnt", resp_cnt - r0, 1);
    chk("wr_fcnt", fan_cnt - f0, 1);

    // misalignment, then simultaneous edge + heading_rdy
    r0 = resp_cnt;
    heading = 12'h000;
    issue(16'h23F1, "mis");
    chk("mis_hdng", dsrd_hdng, 12'h3FF);
    repeat (5) hrdy();
    chk("mis_frwrd", frwrd, 10'h000);
    chk("mis_mov",   moving, 1);
    heading = 12'h3E0;
    hrdy(); chk("mis_al",  frwrd, 10'h000);
    hrdy(); chk("mis_up1", frwrd, 10'h020);
    edge_ir();
    heading_rdy = 1'b1; cntrIR = 1'b1;
    @(negedge clk);
    heading_rdy = 1'b0; cntrIR = 1'b0; #1;
    chk("mis_sim", frwrd, 10'h040);
    chk("mis_sim_nresp", u_if.send_resp, 0);
    hrdy();
    chk("mis_dn",    frwrd, 10'h000);
    chk("mis_sresp", u_if.send_resp, 1);
    cyc(1);
    chk("mis_rcnt", resp_cnt - r0, 1);

    // zero squares
    r0 = resp_cnt;
    heading = 12'h000;
    issue(16'h2000, "zero");
    hrdy();
    chk("zero_sresp", u_if.send_resp, 1);
    chk("zero_frwrd", frwrd, 10'h000);
    cyc(1);
    chk("zero_mov_off", moving, 0);
    chk("zero_rcnt", resp_cnt - r0, 1);

    // unknown opcode
    r0 = resp_cnt;
    u_if.cmd = 16'hF123; u_if.cmd_rdy = 1'b1; #1;
    chk("unk_clr", u_if.clr_cmd_rdy, 1);
    chk("unk_cal", strt_cal, 0);
    @(negedge clk); u_if.cmd_rdy = 1'b0; #1;
    chk("unk_mov", moving, 0);
    cyc(3);
    chk("unk_rcnt", resp_cnt - r0, 0);

    // reset mid-move
    r0 = resp_cnt;
    heading = 12'h10F;
    issue(16'h2101, "rm");
    chk("rm_hdng", dsrd_hdng, 12'h10F);
    hrdy();
    hrdy(); chk("rm_f1", frwrd, 10'h020);
    rst_n = 1'b0; #1;
    chk("rm_frwrd", frwrd, 10'h000);
    chk("rm_mov",   moving, 0);
    chk("rm_hdng0", dsrd_hdng, 12'h000);
    chk("rm_sresp", u_if.send_resp, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    u_if.cmd = 16'h0000; u_if.cmd_rdy = 1'b1; #1;
    chk("rm_cal_clr",  u_if.clr_cmd_rdy, 1);
    chk("rm_cal_strt", strt_cal, 1);
    @(negedge clk); u_if.cmd_rdy = 1'b0;
    cyc(3);
    cal_done = 1'b1; #1;
    chk("rm_cal_sresp", u_if.send_resp, 1);
    @(negedge clk); cal_done = 1'b0; #1;
    chk("rm_rcnt", resp_cnt - r0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
